herloa_err_monitor: RTL



---
 rtl/herloa_err_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/herloa_err_monitor.sv
// rtl/herloa_err_monitor.sv - HERLOA error-metric accumulator with run/report handshake
// Two-stage pipeline (S1: exact sum, S2: error distance) feeding saturating run statistics.
module herloa_err_monitor #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s_approx,
  input  logic             last,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     ed_max,
  output logic [N-1:0]     ed_max_a,
  output logic [N-1:0]     ed_max_b
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, REPORT} state_e;

  state_e state_q, state_d;
  logic   accept;
  logic   clear_acc;

  logic         s1_valid_q;
  logic [N-1:0] s1_exact_q, s1_sapx_q, s1_a_q, s1_b_q;
  logic [N-1:0] s1_ed;

  logic         s2_valid_q;
  logic [N-1:0] s2_ed_q, s2_a_q, s2_b_q;

  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic [ACC_W:0]   ed_sum_ext;
  logic [N-1:0]     ed_max_q, ed_max_d;
  logic [N-1:0]     ed_max_a_q, ed_max_a_d;
  logic [N-1:0]     ed_max_b_q, ed_max_b_d;

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    stat_valid = 1'b0;
    clear_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          clear_acc = 1'b1;
          state_d   = last ? FLUSH : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!s1_valid_q && !s2_valid_q) state_d = REPORT;
      end
      REPORT: begin
        stat_valid = 1'b1;
        if (stat_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Plain magnitude, no modular wrap-back: exact 0 vs approx all-ones is a full-scale error.
  always_comb begin
    s1_ed = (s1_exact_q >= s1_sapx_q) ? (s1_exact_q - s1_sapx_q) : (s1_sapx_q - s1_exact_q);
  end

  // The pipeline is always empty in IDLE, so clearing never races a pending S2 update.
  always_comb begin
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    ed_sum_d       = ed_sum_q;
    ed_max_d       = ed_max_q;
    ed_max_a_d     = ed_max_a_q;
    ed_max_b_d     = ed_max_b_q;
    ed_sum_ext     = {1'b0, ed_sum_q} + {{(ACC_W + 1 - N){1'b0}}, s2_ed_q};
    if (clear_acc) begin
      sample_count_d = '0;
      err_count_d    = '0;
      ed_sum_d       = '0;
      ed_max_d       = '0;
      ed_max_a_d     = '0;
      ed_max_b_d     = '0;
    end else if (s2_valid_q) begin
      if (!(&sample_count_q)) sample_count_d = sample_count_q + CNT_W'(1);
      if ((s2_ed_q != '0) && !(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
      ed_sum_d = ed_sum_ext[ACC_W] ? '1 : ed_sum_ext[ACC_W-1:0];
      if (s2_ed_q > ed_max_q) begin
        ed_max_d   = s2_ed_q;
        ed_max_a_d = s2_a_q;
        ed_max_b_d = s2_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_valid_q     <= 1'b0;
      s1_exact_q     <= '0;
      s1_sapx_q      <= '0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s2_valid_q     <= 1'b0;
      s2_ed_q        <= '0;
      s2_a_q         <= '0;
      s2_b_q         <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      ed_sum_q       <= '0;
      ed_max_q       <= '0;
      ed_max_a_q     <= '0;
      ed_max_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q <= a + b;
        s1_sapx_q  <= s_approx;
        s1_a_q     <= a;
        s1_b_q     <= b;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ed_q <= s1_ed;
        s2_a_q  <= s1_a_q;
        s2_b_q  <= s1_b_q;
      end
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      ed_sum_q       <= ed_sum_d;
      ed_max_q       <= ed_max_d;
      ed_max_a_q     <= ed_max_a_d;
      ed_max_b_q     <= ed_max_b_d;
    end
  end

  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign ed_sum       = ed_sum_q;
  assign ed_max       = ed_max_q;
  assign ed_max_a     = ed_max_a_q;
  assign ed_max_b     = ed_max_b_q;

endmodule
